// File: rtl/timer_pkg.sv
// Shared definitions for the board timers: FSM states, field limits and the
// active-low 7-segment digit table ({g,f,e,d,c,b,a}).
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  localparam logic [6:0] MIN_MAX = 7'd99;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [6:0] CS_MAX  = 7'd99;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Split a 0..99 field into its two decimal digits.
  function automatic bcd_t to_bcd(input logic [6:0] v);
    bcd_t b;
    b.tens  = 4'(v / 7'd10);
    b.units = 4'(v % 7'd10);
    return b;
  endfunction

  function automatic logic [6:0] sat7(input logic [6:0] v, input logic [6:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Single-digit decoder: 4-bit digit to active-low segment code; codes outside
// 0..9 render blank.
module seg7_dec
  import timer_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds:centiseconds count-down timer driving six 7-segment digits.
// Optional feature: define COUNTDOWN_BLINK_EN to blink the display in DONE.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_DIV = 500000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [6:0] set_min,
  input  logic [5:0] set_sec,
  output logic       running,
  output logic       done,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  localparam int              DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           state_q, state_n;
  logic [6:0]       min_q, min_n;
  logic [5:0]       sec_q, sec_n;
  logic [6:0]       cs_q, cs_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic             tick;
  logic             preset_zero;
`ifdef COUNTDOWN_BLINK_EN
  logic [5:0]       blink_q, blink_n;
`endif

  assign tick        = (div_q == DIV_LAST);
  assign preset_zero = (min_q == '0) && (sec_q == '0) && (cs_q == '0);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_n = state_q;
    min_n   = min_q;
    sec_n   = sec_q;
    cs_n    = cs_q;
    div_n   = div_q;
`ifdef COUNTDOWN_BLINK_EN
    blink_n = blink_q;
`endif

    if (load) begin
      min_n   = sat7(set_min, MIN_MAX);
      sec_n   = 6'(sat7({1'b0, set_sec}, {1'b0, SEC_MAX}));
      cs_n    = '0;
      div_n   = '0;
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !preset_zero) begin
            state_n = RUN;
            div_n   = '0;
          end
        end

        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (tick) begin
            div_n = '0;
            if (cs_q != '0) begin
              cs_n = cs_q - 7'd1;
            end else if (sec_q != '0) begin
              sec_n = sec_q - 6'd1;
              cs_n  = CS_MAX;
            end else if (min_q != '0) begin
              min_n = min_q - 7'd1;
              sec_n = SEC_MAX;
              cs_n  = CS_MAX;
            end
            // The tick that writes 00:00.00 is also the DONE transition.
            if ((min_n == '0) && (sec_n == '0) && (cs_n == '0)) begin
              state_n = DONE;
`ifdef COUNTDOWN_BLINK_EN
              blink_n = '0;
`endif
            end
          end else begin
            div_n = div_q + DIV_W'(1);
          end
        end

        PAUSED: begin
          if (!pause) state_n = RUN;
        end

        DONE: begin
`ifdef COUNTDOWN_BLINK_EN
          // Prescaler keeps running so the blink counter advances per tick.
          if (tick) begin
            div_n   = '0;
            blink_n = blink_q + 6'd1;
          end else begin
            div_n = div_q + DIV_W'(1);
          end
`endif
        end

        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      cs_q    <= '0;
      div_q   <= '0;
`ifdef COUNTDOWN_BLINK_EN
      blink_q <= '0;
`endif
    end else if (en) begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q <= state_n;
      min_q   <= min_n;
      sec_q   <= sec_n;
      cs_q    <= cs_n;
      div_q   <= div_n;
`ifdef COUNTDOWN_BLINK_EN
      blink_q <= blink_n;
`endif
    end
  end

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

  // Display: digit 2k is the units and 2k+1 the tens of field k (cs, sec, min).
  bcd_t       fld   [3];
  logic [3:0] digit [6];
  logic [6:0] seg   [6];
  logic       blank;

  assign fld[0] = to_bcd(cs_q);
  assign fld[1] = to_bcd({1'b0, sec_q});
  assign fld[2] = to_bcd(min_q);

  for (genvar k = 0; k < 3; k++) begin : g_field
    assign digit[2*k]   = fld[k].units;
    assign digit[2*k+1] = fld[k].tens;
  end

  for (genvar d = 0; d < 6; d++) begin : g_dec
    seg7_dec u_dec (
      .digit(digit[d]),
      .seg  (seg[d])
    );
  end

`ifdef COUNTDOWN_BLINK_EN
  assign blank = (state_q == DONE) && blink_q[5];
`else
  assign blank = 1'b0;
`endif

  assign HEX0 = blank ? SEG_BLANK : seg[0];
  assign HEX1 = blank ? SEG_BLANK : seg[1];
  assign HEX2 = blank ? SEG_BLANK : seg[2];
  assign HEX3 = blank ? SEG_BLANK : seg[3];
  assign HEX4 = blank ? SEG_BLANK : seg[4];
  assign HEX5 = blank ? SEG_BLANK : seg[5];

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with literal
// expectations, then randomized stimulus against a remaining-time model.
module tb_countdown_timer;

  localparam int CLK_DIV = 2;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] set_min = '0;
  logic [5:0] set_sec = '0;
  logic       running, done;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int n_checks = 0;
  int n_err    = 0;

  countdown_timer #(.CLK_DIV(CLK_DIV)) dut (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .en     (en),
    .load   (load),
    .start  (start),
    .pause  (pause),
    .set_min(set_min),
    .set_sec(set_sec),
    .running(running),
    .done   (done),
    .HEX0   (HEX0),
    .HEX1   (HEX1),
    .HEX2   (HEX2),
    .HEX3   (HEX3),
    .HEX4   (HEX4),
    .HEX5   (HEX5)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] T [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Model: remaining time as one centisecond count, plus a prescale phase.
  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mst_t;
  mst_t m_st  = M_IDLE;
  int   m_rem = 0;
  int   m_pre = 0;
  int   m_blk = 0;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      m_st  <= M_IDLE;
      m_rem <= 0;
      m_pre <= 0;
      m_blk <= 0;
    end else if (en) begin
      if (load) begin
        m_rem <= sat(int'(set_min), 99) * 6000 + sat(int'(set_sec), 59) * 100;
        m_pre <= 0;
        m_st  <= M_IDLE;
      end else begin
        case (m_st)
          M_IDLE:
            if (start && m_rem != 0) begin
              m_st  <= M_RUN;
              m_pre <= 0;
            end
          M_RUN:
            if (pause) m_st <= M_PAUSED;
            else if (m_pre == CLK_DIV - 1) begin
              m_pre <= 0;
              m_rem <= m_rem - 1;
              if (m_rem == 1) begin
                m_st  <= M_DONE;
                m_blk <= 0;
              end
            end else m_pre <= m_pre + 1;
          M_PAUSED:
            if (!pause) m_st <= M_RUN;
          M_DONE:
            if (m_pre == CLK_DIV - 1) begin
              m_pre <= 0;
              m_blk <= m_blk + 1;
            end else m_pre <= m_pre + 1;
          default: m_st <= M_IDLE;
        endcase
      end
    end
  end

  function automatic logic [41:0] hex_of(input int m, input int s, input int c);
    return {T[m / 10], T[m % 10], T[s / 10], T[s % 10], T[c / 10], T[c % 10]};
  endfunction

  function automatic logic [41:0] model_hex();
    bit blank;
    blank = 1'b0;
`ifdef COUNTDOWN_BLINK_EN
    blank = (m_st == M_DONE) && ((m_blk % 64) >= 32);
`endif
    if (blank) return {6{7'b1111111}};
    return hex_of(m_rem / 6000, (m_rem / 100) % 60, m_rem % 100);
  endfunction

  function automatic logic [41:0] dut_hex();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_running", 64'(running), 64'(m_st == M_RUN));
    check("model_done",    64'(done),    64'(m_st == M_DONE));
    check("model_hex",     64'(dut_hex()), 64'(model_hex()));
  endtask

  // Advance n clock edges; compare against the model at each falling edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
      compare_model();
      #1;
    end
  endtask

  task automatic do_load(input int m, input int s);
    set_min = 7'(m);
    set_sec = 6'(s);
    load    = 1'b1;
    cycles(1);
    load    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    #1 rst_n = 1'b1;
    compare_model();
    check("reset_running", 64'(running), 64'd0);
    check("reset_done",    64'(done),    64'd0);
    check("reset_hex",     64'(dut_hex()), 64'({6{7'b1000000}}));

    // 00:01.00 runs out after 100 ticks = 200 clocks.
    do_load(0, 1);
    do_start();
    check("start_running", 64'(running), 64'd1);
    cycles(199);
    check("done_not_early", 64'(done), 64'd0);
    cycles(1);
    check("done_set",     64'(done),    64'd1);
    check("done_running", 64'(running), 64'd0);
    check("done_hex",     64'(dut_hex()), 64'({6{7'b1000000}}));
    start = 1'b1;
    pause = 1'b1;
    cycles(63);
    start = 1'b0;
    pause = 1'b0;
    check("done_holds", 64'(done), 64'd1);
    check("done_visible_31", 64'(HEX0), 64'(7'b1000000));
    cycles(1);
`ifdef COUNTDOWN_BLINK_EN
    check("done_blank_32", 64'(dut_hex()), 64'({6{7'b1111111}}));
`else
    check("done_steady_32", 64'(dut_hex()), 64'({6{7'b1000000}}));
`endif
    cycles(80);

    // 01:00.00 minus one tick borrows through every field.
    do_load(1, 0);
    do_start();
    cycles(2);
    check("borrow_hex",  64'(dut_hex()), 64'(hex_of(0, 59, 99)));
    check("borrow_hex0", 64'(HEX0), 64'(7'b0010000));

    // Clamp, then a zero preset refuses to start.
    do_load(120, 63);
    check("clamp_hex", 64'(dut_hex()), 64'(hex_of(99, 59, 0)));
    check("clamp_idle", 64'(running), 64'd0);
    do_load(0, 0);
    start = 1'b1;
    cycles(3);
    start = 1'b0;
    check("zero_no_run",  64'(running), 64'd0);
    check("zero_no_done", 64'(done),    64'd0);

    // Pause after 10 ticks, then en=0 blocks a load while frozen.
    do_load(0, 5);
    do_start();
    cycles(20);
    check("ten_ticks_hex", 64'(dut_hex()), 64'(hex_of(0, 4, 90)));
    pause = 1'b1;
    cycles(50);
    check("paused_hex", 64'(dut_hex()), 64'(hex_of(0, 4, 90)));
    check("paused_not_running", 64'(running), 64'd0);
    en      = 1'b0;
    set_min = 7'd0;
    set_sec = 6'd9;
    load    = 1'b1;
    cycles(10);
    check("en_blocks_load", 64'(dut_hex()), 64'(hex_of(0, 4, 90)));
    en    = 1'b1;
    load  = 1'b0;
    pause = 1'b0;
    cycles(1);
    check("resume_running", 64'(running), 64'd1);
    cycles(6);

    // load beats start on the same edge.
    set_min = 7'd0;
    set_sec = 6'd7;
    load    = 1'b1;
    start   = 1'b1;
    cycles(1);
    load    = 1'b0;
    start   = 1'b0;
    check("load_over_start_run", 64'(running), 64'd0);
    check("load_over_start_hex", 64'(dut_hex()), 64'(hex_of(0, 7, 0)));

    // Asynchronous reset in the middle of a run.
    do_start();
    cycles(5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_running", 64'(running), 64'd0);
    check("async_rst_hex", 64'(dut_hex()), 64'({6{7'b1000000}}));
    @(negedge CLK);
    #1 rst_n = 1'b1;

    // Randomized phase, every cycle checked against the model.
    for (int i = 0; i < 20000; i++) begin
      en   = ($urandom_range(0, 19) != 0);
      load = ($urandom_range(0, 499) == 0);
      if (load) begin
        if ($urandom_range(0, 7) == 0) begin
          set_min = 7'($urandom_range(0, 127));
          set_sec = 6'($urandom_range(0, 63));
        end else begin
          set_min = 7'd0;
          set_sec = 6'($urandom_range(0, 2));
        end
      end
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      cycles(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Down-counting minutes:seconds:centiseconds timer for the DE-series board experiments; the count-down counterpart of the stopwatch timer. Loads a preset from switches, counts down to 00:00.00 at a 100 Hz tick derived from `CLK`, then raises `done`. Drives the six on-board 7-segment displays (active-low segments) with the same digit layout as the stopwatch: HEX5..HEX4 minutes, HEX3..HEX2 seconds, HEX1..HEX0 centiseconds.

## Interface
- `CLK_DIV`, default 500000: `CLK` cycles per centisecond tick (50 MHz → 100 Hz); must be ≥ 2.
- `CLK`  input  1  system clock, rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `en`  input  1  global enable; low freezes all state, including the prescaler.
- `load`  input  1  capture `set_min`/`set_sec`, go to IDLE.
- `start`  input  1  begin counting from IDLE (level-sampled).
- `pause`  input  1  level; high holds the count while running.
- `set_min`  input  7  preset minutes, clamped to 99.
- `set_sec`  input  6  preset seconds, clamped to 59.
- `running`  output  1  high in RUN.
- `done`  output  1  high in DONE.
- `HEX0`..`HEX5`  output  7 each  segment codes {g,f,e,d,c,b,a}, active-low.

## Operation
- Registers: `cs` (0–99), `sec` (0–59), `min` (0–99), prescaler `div` (0..CLK_DIV-1), FSM state.
- States: IDLE, RUN, PAUSED, DONE. Reset: IDLE, all counters 0, `done`=0, `running`=0, every HEX = 7'b1000000 ("0").
- Priority per enabled edge: `load` > `start` > `pause` > tick.
- `load` (any state): min←min(set_min,99), sec←min(set_sec,59), cs←0, div←0, state←IDLE.
- IDLE + `start`: if preset nonzero → RUN, div←0; if preset is 00:00.00 → stay IDLE.
- RUN + `pause` → PAUSED (div held). PAUSED + !`pause` → RUN (div resumes).
- RUN: div increments; at div==CLK_DIV-1, div←0 and tick fires. Tick decrement: cs>0 → cs-1; else sec>0 → sec-1, cs←99; else min>0 → min-1, sec←59, cs←99.
- Tick producing 00:00.00 → DONE on the same edge. DONE holds until `load`; `start` and `pause` are ignored in DONE.
- `en`=0: no register changes, including `load`. Outputs keep their last values.
- HEX digits: combinational decode of tens/units of each field, via a digit→segment table (0–9 only).

## Timing
- From `start` sampled at edge N: first decrement at edge N+CLK_DIV.
- `done`/`running` are registered; `done` rises on the edge that writes 00:00.00.
- HEX outputs follow the registers combinationally; no added latency.
- Async assertion of `rst_n` mid-count: immediate IDLE/zero. Deassertion is synchronised externally.
- Full preset 99:59.00 → DONE after exactly 599 900 ticks.

## Configuration
- `COUNTDOWN_BLINK_EN` defined: in DONE, a 6-bit tick counter keeps running. HEX0–HEX5 show 7'b1111111 (blank) while its bit 5 is 1, otherwise 00:00.00. The display toggles every 32 ticks. The counter clears on entry to DONE, so the display starts visible.
- Undefined: DONE displays a steady 00:00.00. No blink counter is synthesised.

## Structure
- Shared package `timer_pkg`: state enum (IDLE/RUN/PAUSED/DONE), 10-entry 7-segment digit table, blank code 7'b1111111, limits 99/59/99.
- One sub-module `seg7_dec`: 4-bit digit → 7-bit active-low code, instantiated six times; the stopwatch may share it.

## Test plan
- CLK_DIV=2; load 00:01.00, start → `running`=1; after 100 ticks (200 clk) HEX shows 00:00.00, `done`=1, `running`=0.
- Load 01:00.00, start, 1 tick → min=0, sec=59, cs=99; HEX = 00:59.99.
- Load set_min=120, set_sec=63 → clamped 99:59.00; start with preset 00:00.00 → stays IDLE, `done`=0.
- Run 10 ticks, assert `pause` 50 clk, release → count frozen during pause, resumes with no lost or extra tick; `en`=0 likewise freezes and also blocks `load`.
- `load` and `start` on the same edge while in RUN → IDLE with new preset; `rst_n` low mid-RUN → immediate IDLE, all HEX = 7'b1000000.
- With `COUNTDOWN_BLINK_EN` defined: in DONE, HEX alternates 00:00.00 / blank every 32 ticks; without the macro, a steady 00:00.00.
